// File: rtl/alu_seq.sv
// alu_seq: registered RISC-V ALU with a valid/ready operand handshake,
// a held result under backpressure, and signed/unsigned compares.
// Iterative shift-add multiply and restoring divide (RV32M subset) are
// built only when ALU_SEQ_MULDIV_EN is defined. Without it, opcodes with
// bit 4 set complete in one cycle as undefined ops (c=0, flags 0).
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// CALC  | mul/div iterating, one bit per cycle for DATA_WIDTH cycles
// DONE  | result registered, out_valid high until out_ready
module alu_seq #(
    parameter int DATA_WIDTH = 32,
    parameter int CTRL_BITS  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CTRL_BITS-1:0]  ctrl,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] c,
    output logic                  zero,
    output logic                  over,
    output logic                  c_out,
    output logic                  busy
);
    localparam int W = DATA_WIDTH;

    localparam logic [CTRL_BITS-1:0] OP_AND   = CTRL_BITS'(5'b00000);
    localparam logic [CTRL_BITS-1:0] OP_XOR   = CTRL_BITS'(5'b00001);
    localparam logic [CTRL_BITS-1:0] OP_ADD   = CTRL_BITS'(5'b00010);
    localparam logic [CTRL_BITS-1:0] OP_OR    = CTRL_BITS'(5'b00011);
    localparam logic [CTRL_BITS-1:0] OP_SGE   = CTRL_BITS'(5'b00101);
    localparam logic [CTRL_BITS-1:0] OP_SUB   = CTRL_BITS'(5'b00110);
    localparam logic [CTRL_BITS-1:0] OP_SLT   = CTRL_BITS'(5'b00111);
    localparam logic [CTRL_BITS-1:0] OP_NOR   = CTRL_BITS'(5'b01100);
    localparam logic [CTRL_BITS-1:0] OP_SLTU  = CTRL_BITS'(5'b01111);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state_q, state_d;
    logic            accept;
    logic            md_op;
    logic            calc_last;
    logic [W-1:0]    md_res;

    logic [W-1:0]    b_eff, add_sum, sc_res;
    logic            is_sub, add_cout, add_over, sc_arith;

    logic [W-1:0]    c_q;
    logic            zero_q, over_q, cout_q;

    assign accept = in_valid && (state_q == IDLE);
    assign c      = c_q;
    assign zero   = zero_q;
    assign over   = over_q;
    assign c_out  = cout_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_d = md_op ? CALC : DONE;
            end
            CALC: begin
                if (calc_last) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Single-cycle ops; SUB reuses the adder as a + ~b + 1.
    always_comb begin
        is_sub              = (ctrl == OP_SUB);
        b_eff               = is_sub ? ~b : b;
        {add_cout, add_sum} = {1'b0, a} + {1'b0, b_eff} + (W+1)'(is_sub);
        add_over            = (a[W-1] == b_eff[W-1]) && (add_sum[W-1] != a[W-1]);
        sc_res              = '0;
        sc_arith            = 1'b0;
        case (ctrl)
            OP_AND:  sc_res = a & b;
            OP_XOR:  sc_res = a ^ b;
            OP_OR:   sc_res = a | b;
            OP_NOR:  sc_res = ~(a | b);
            OP_ADD, OP_SUB: begin
                sc_res   = add_sum;
                sc_arith = 1'b1;
            end
            OP_SGE:  sc_res = W'($signed(a) >= $signed(b));
            OP_SLT:  sc_res = W'($signed(a) < $signed(b));
            OP_SLTU: sc_res = W'(a < b);
            default: sc_res = '0;
        endcase
    end

`ifdef ALU_SEQ_MULDIV_EN
    localparam logic [CTRL_BITS-1:0] OP_MUL   = CTRL_BITS'(5'b10000);
    localparam logic [CTRL_BITS-1:0] OP_MULH  = CTRL_BITS'(5'b10001);
    localparam logic [CTRL_BITS-1:0] OP_MULHU = CTRL_BITS'(5'b10011);
    localparam logic [CTRL_BITS-1:0] OP_DIV   = CTRL_BITS'(5'b10100);
    localparam logic [CTRL_BITS-1:0] OP_DIVU  = CTRL_BITS'(5'b10101);
    localparam logic [CTRL_BITS-1:0] OP_REM   = CTRL_BITS'(5'b10110);
    localparam logic [CTRL_BITS-1:0] OP_REMU  = CTRL_BITS'(5'b10111);
    localparam int CNT_W = $clog2(DATA_WIDTH);

    logic [2*W-1:0]       acc_q, acc_step, prod;
    logic [W-1:0]         opnd_q, a_q, a_mag, b_mag, quot, rem, diff;
    logic [W:0]           mul_hi, trial;
    logic [CNT_W-1:0]     cnt_q;
    logic [CTRL_BITS-1:0] op_q;
    logic                 md_signed, sa_q, sb_q, div_ge, is_div;

    // Decode mul/div opcodes and take operand magnitudes for signed variants.
    always_comb begin
        md_op     = 1'b0;
        md_signed = 1'b0;
        case (ctrl)
            OP_MUL, OP_MULHU, OP_DIVU, OP_REMU: md_op = 1'b1;
            OP_MULH, OP_DIV, OP_REM: begin
                md_op     = 1'b1;
                md_signed = 1'b1;
            end
            default: md_op = 1'b0;
        endcase
        a_mag = (md_signed && a[W-1]) ? -a : a;
        b_mag = (md_signed && b[W-1]) ? -b : b;
    end

    // One iteration step plus final sign fix-up and result selection.
    // Divide-by-zero falls out of the restoring loop for unsigned ops but
    // is forced explicitly so signed ops give the same all-ones / a result.
    always_comb begin
        is_div = op_q[2];
        mul_hi = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        trial  = acc_q[2*W-1:W-1];
        div_ge = (trial >= {1'b0, opnd_q});
        diff   = trial[W-1:0] - opnd_q;
        if (is_div) acc_step = {(div_ge ? diff : trial[W-1:0]), acc_q[W-2:0], div_ge};
        else        acc_step = {mul_hi, acc_q[W-1:1]};
        prod = (sa_q ^ sb_q) ? -acc_step : acc_step;
        quot = (sa_q ^ sb_q) ? -acc_step[W-1:0] : acc_step[W-1:0];
        rem  = sa_q ? -acc_step[2*W-1:W] : acc_step[2*W-1:W];
        if (opnd_q == '0) begin
            quot = '1;
            rem  = a_q;
        end
        case (op_q)
            OP_MUL:            md_res = prod[W-1:0];
            OP_MULH, OP_MULHU: md_res = prod[2*W-1:W];
            OP_DIV, OP_DIVU:   md_res = quot;
            OP_REM, OP_REMU:   md_res = rem;
            default:           md_res = '0;
        endcase
    end

    assign calc_last = (cnt_q == '0);

    // Iteration registers: loaded on accept, stepped every CALC cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q  <= '0;
            opnd_q <= '0;
            a_q    <= '0;
            op_q   <= '0;
            sa_q   <= 1'b0;
            sb_q   <= 1'b0;
            cnt_q  <= '0;
        end else if (accept) begin
            acc_q  <= {{W{1'b0}}, a_mag};
            opnd_q <= b_mag;
            a_q    <= a;
            op_q   <= ctrl;
            sa_q   <= md_signed && a[W-1];
            sb_q   <= md_signed && b[W-1];
            cnt_q  <= CNT_W'(DATA_WIDTH - 1);
        end else if (state_q == CALC) begin
            acc_q  <= acc_step;
            cnt_q  <= cnt_q - CNT_W'(1);
        end
    end
`else
    assign md_op     = 1'b0;
    assign calc_last = 1'b1;
    assign md_res    = '0;
`endif

    // Result and flag registers; updated only when a new result is produced.
    always_ff @(posedge clk) begin
        if (rst) begin
            c_q    <= '0;
            zero_q <= 1'b1;
            over_q <= 1'b0;
            cout_q <= 1'b0;
        end else if (accept && !md_op) begin
            c_q    <= sc_res;
            zero_q <= (sc_res == '0);
            over_q <= sc_arith && add_over;
            cout_q <= sc_arith && add_cout;
        end else if ((state_q == CALC) && calc_last) begin
            c_q    <= md_res;
            zero_q <= (md_res == '0);
            over_q <= 1'b0;
            cout_q <= 1'b0;
        end
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Registered, parametrised ALU for the RISC-V datapath: next generation of the combinational ALU.
- Adds a valid/ready operand handshake, a registered result with backpressure, and signed/unsigned compares.
- Adds iterative multiply/divide (RV32M subset) that runs for DATA_WIDTH cycles.
- Sits between operand fetch and writeback; the pipeline control stalls on in_ready/out_valid.

Parameters:
- DATA_WIDTH, 32, operand/result width (>=8).
- CTRL_BITS, 5, opcode width; bit 4 set selects a mul/div op.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands/opcode presented
- in_ready  output  1  block can accept; high only in IDLE
- ctrl  input  CTRL_BITS  opcode
- a  input  DATA_WIDTH  operand A
- b  input  DATA_WIDTH  operand B
- out_valid  output  1  result registered and held
- out_ready  input  1  consumer takes result
- c  output  DATA_WIDTH  result
- zero  output  1  c == 0
- over  output  1  signed overflow (ADD/SUB only)
- c_out  output  1  carry out (ADD/SUB only)
- busy  output  1  state != IDLE

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values: c=0, zero=1, over=0, c_out=0, out_valid=0, busy=0, in_ready=1, state=IDLE.
- Reset mid-operation aborts the op; the result is discarded and no out_valid is produced.
- Opcodes, single-cycle:
  - AND 00000, XOR 00001, ADD 00010, OR 00011, SGE 00101 (signed a>=b), SUB 00110, SLT 00111 (signed a<b), NOR 01100, SLTU 01111 (unsigned a<b).
  - Compare results are 1 or 0, zero-extended.
- Opcodes, mul/div:
  - MUL 10000 (low W bits).
  - MULH 10001 (high W bits, signed x signed); MULHU 10011 (high W bits, unsigned).
  - DIV 10100, DIVU 10101, REM 10110, REMU 10111.
- Undefined opcode: single-cycle; c=0, flags 0.
- Handshake: transfer on the cycle where in_valid && in_ready. a, b and ctrl are captured and need not stay stable afterwards.
- FSM transitions:
  - IDLE -> DONE on accepting a single-cycle op.
  - IDLE -> CALC on accepting a mul/div op.
  - CALC -> DONE after exactly DATA_WIDTH iteration cycles.
  - DONE -> IDLE when out_ready is high.
- out_valid = (state==DONE). c and flags are stable while DONE and change only on a new result.
- Latency from accept to out_valid: single-cycle ops 1 clk; mul/div DATA_WIDTH+1 clks (33 at default).
- If out_ready is high in the first DONE cycle, in_ready rises the next cycle. No accept is possible while in DONE.
- ADD/SUB arithmetic:
  - W-bit wrap. SUB computes a + ~b + 1.
  - c_out is the carry out of the MSB; SUB c_out=1 means no borrow.
  - over = carry into MSB XOR carry out of MSB.
- Multiplier: shift-add, one partial product per cycle, 2W-bit accumulator. Signed variants convert operands to magnitudes and negate the product when signs differ.
- Divider: restoring, one quotient bit per cycle. Signed variants divide magnitudes; quotient sign = sign(a)^sign(b); remainder sign = sign(a).
- Divide by zero: quotient = all ones; remainder = a.
- Signed overflow (a = -2^(W-1), b = -1): DIV returns a; REM returns 0; over stays 0.
- zero is recomputed from the registered c for every op.

Optional Feature:
- Macro: ALU_SEQ_MULDIV_EN.
- Defined: mul/div ops implemented as above.
- Undefined: no multiplier/divider logic. Opcodes with bit 4 set are treated as undefined opcodes: 1-cycle, c=0, flags 0, CALC never entered.

Test Plan:
- ADD a=32'h80000000, b=32'h80000000 -> 1 clk later out_valid=1, c=0, zero=1, over=1, c_out=1.
- SUB a=75, b=25 -> c=50, c_out=1, over=0. SLT a=32'hFFFFBEEF, b=3 -> c=1. SLTU with the same operands -> c=0.
- MULH a=-2 (32'hFFFFFFFE), b=3 -> out_valid exactly 33 clks after accept, c=32'hFFFFFFFF. MUL with the same operands -> c=32'hFFFFFFFA.
- DIV a=-7, b=2 -> c=-3. REM a=-7, b=2 -> c=-1. DIVU a=7, b=0 -> c=32'hFFFFFFFF. REMU a=7, b=0 -> c=7. DIV a=32'h80000000, b=-1 -> c=32'h80000000.
- Backpressure: hold out_ready=0 for 5 clks after out_valid -> c/flags held, in_ready=0. Raise out_ready -> in_ready=1 next clk; next op accepted.
- Assert rst at the 10th CALC cycle of DIVU -> next clk: state IDLE, out_valid=0, c=0, zero=1, in_ready=1. A following ADD 1+2 returns 3.
